// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer block engine.
//   fb_state_e    : engine state encoding
//   GEOM_W        : width of the frame geometry fields (stride/width/height)
//   POS_W         : width of the block position inputs
//   PROD_W        : width at which y*stride + x is formed before truncation
//   DEF_*         : default parameter values for the engine
//   mem_width_ok(): true when a memory word holds exactly one block line
package fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR,
    ST_DONE
  } fb_state_e;

  localparam int GEOM_W = 12;
  localparam int POS_W  = 11;
  localparam int PROD_W = 23;

  localparam int DEF_MEM_WIDTH  = 64;
  localparam int DEF_BLK_WIDTH  = 8;
  localparam int DEF_BLK_HEIGHT = 8;
  localparam int DEF_ADDR_WIDTH = 21;

  // One memory word must carry one block line of 8-bit pixels.
  function automatic bit mem_width_ok(input int mem_w, input int blk_w);
    return mem_w == blk_w * 8;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Address generator shared by the block-read and frame-write paths.
// Forms addr = y_eff*stride + x_eff at PROD_W bits, truncated to ADDR_WIDTH.
// With clamp_en_i set the coordinates are clamped to the frame edge
// (edge replication); with it clear they pass through unchanged.
//   clamp_en_i : apply edge clamping (block reads)
//   x_i, y_i   : requested pixel column / line
//   stride_i   : line pitch in pixels
//   width_i    : frame width in pixels
//   height_i   : frame height in lines
//   addr_o     : resulting pixel/byte address
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int BLK_WIDTH  = DEF_BLK_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clamp_en_i,
  input  logic [GEOM_W-1:0]     x_i,
  input  logic [GEOM_W-1:0]     y_i,
  input  logic [GEOM_W-1:0]     stride_i,
  input  logic [GEOM_W-1:0]     width_i,
  input  logic [GEOM_W-1:0]     height_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam logic [GEOM_W-1:0] BLK_W_G = GEOM_W'(BLK_WIDTH);

  logic [GEOM_W-1:0] y_max;
  logic [GEOM_W-1:0] x_max;
  logic [GEOM_W-1:0] x_eff;
  logic [GEOM_W-1:0] y_eff;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] sum;

  assign y_max = height_i - GEOM_W'(1);
  assign x_max = width_i - BLK_W_G;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it holding its old value, which would infer a latch.
    x_eff = x_i;
    y_eff = y_i;
    if (clamp_en_i) begin
      if (y_i > y_max) y_eff = y_max;
      // A frame narrower than one block always reads from column 0.
      if (width_i < BLK_W_G)  x_eff = '0;
      else if (x_i > x_max)   x_eff = x_max;
    end
    prod   = PROD_W'(y_eff) * PROD_W'(stride_i);
    sum    = prod + PROD_W'(x_eff);
    addr_o = ADDR_WIDTH'(sum);
  end

endmodule

// File: rtl/fb_block_engine.sv
// Frame-buffer engine between the pixel pipeline and frame memory.
// Streams a frame into memory in raster order (fb_* handshake) and fetches
// BLK_WIDTH x BLK_HEIGHT blocks one line per memory word, replicating the
// frame edge for lines/columns outside the frame. One outstanding read.
//   clk, reset            : clock, synchronous active-low reset
//   stride_in/width_in/
//   height_in, setup_frame: frame geometry and its latch strobe (IDLE only)
//   x, y, read_block      : block position and fetch start (IDLE only)
//   blk_line, blk_line_rdy,
//   blk_done              : fetched line, its valid pulse, last-line pulse
//   fb_write, fb_data,
//   fb_valid, fb_ready,
//   fb_done               : frame-write start, data handshake, completion
//   busy                  : engine not idle
//   mem_addr, mem_data_out,
//   mem_read, mem_write,
//   mem_ready, mem_data,
//   mem_rvalid            : frame-memory request / return interface
module fb_block_engine
  import fb_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int BLK_WIDTH  = DEF_BLK_WIDTH,
  parameter int BLK_HEIGHT = DEF_BLK_HEIGHT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GEOM_W-1:0]     stride_in,
  input  logic [GEOM_W-1:0]     width_in,
  input  logic [GEOM_W-1:0]     height_in,
  input  logic                  setup_frame,
  input  logic [POS_W-1:0]      x,
  input  logic [POS_W-1:0]      y,
  input  logic                  read_block,
  output logic [MEM_WIDTH-1:0]  blk_line,
  output logic                  blk_line_rdy,
  output logic                  blk_done,
  input  logic                  fb_write,
  input  logic [MEM_WIDTH-1:0]  fb_data,
  input  logic                  fb_valid,
  output logic                  fb_ready,
  output logic                  fb_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_data_out,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ready,
  input  logic [MEM_WIDTH-1:0]  mem_data,
  input  logic                  mem_rvalid
);

  localparam int ROW_W = (BLK_HEIGHT > 1) ? $clog2(BLK_HEIGHT) : 1;

  if (!mem_width_ok(MEM_WIDTH, BLK_WIDTH)) begin : g_bad_width
    $error("fb_block_engine: MEM_WIDTH must equal BLK_WIDTH*8");
  end

  fb_state_e state_q, state_d;

  logic [GEOM_W-1:0]     stride_q, width_q, height_q;
  logic [POS_W-1:0]      bx_q, by_q;
  logic [ROW_W-1:0]      row_q;
  logic [GEOM_W-1:0]     x_pos_q, y_pos_q;
  logic                  last_q;          // final frame beat already taken
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [MEM_WIDTH-1:0]  wr_data_q;
  logic                  mem_write_q;
  logic [MEM_WIDTH-1:0]  blk_line_q;
  logic                  blk_line_rdy_q;
  logic                  blk_done_q;

  logic                  rd_active;
  logic                  last_row;
  logic                  wr_accept;
  logic                  fb_fire;
  logic [GEOM_W:0]       x_next;          // one extra bit so +BLK_WIDTH cannot wrap
  logic                  line_wrap;
  logic                  last_beat;
  logic [GEOM_W-1:0]     gen_x, gen_y;
  logic [ADDR_WIDTH-1:0] gen_addr;

  assign rd_active = (state_q == ST_RD_REQ);
  assign last_row  = (row_q == ROW_W'(BLK_HEIGHT - 1));
  assign wr_accept = mem_write_q && mem_ready;
  assign fb_fire   = fb_valid && fb_ready;
  assign x_next    = {1'b0, x_pos_q} + (GEOM_W + 1)'(BLK_WIDTH);
  assign line_wrap = (x_next >= {1'b0, width_q});
  assign last_beat = line_wrap && (y_pos_q == (height_q - GEOM_W'(1)));

  // The read path owns the generator while requesting; otherwise it serves
  // the write path, which needs no clamping.
  assign gen_x = rd_active ? GEOM_W'(bx_q) : x_pos_q;
  assign gen_y = rd_active ? (GEOM_W'(by_q) + GEOM_W'(row_q)) : y_pos_q;

  fb_addr_gen #(
    .BLK_WIDTH  (BLK_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clamp_en_i (rd_active),
    .x_i        (gen_x),
    .y_i        (gen_y),
    .stride_i   (stride_q),
    .width_i    (width_q),
    .height_i   (height_q),
    .addr_o     (gen_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (setup_frame) begin
          state_d = ST_IDLE;
        end else if (fb_write) begin
          state_d = ((width_q == '0) || (height_q == '0)) ? ST_DONE : ST_WR;
        end else if (read_block) begin
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ:  if (mem_ready)  state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (mem_rvalid) state_d = last_row ? ST_IDLE : ST_RD_REQ;
      ST_WR:      if (last_q && wr_accept) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    mem_read     = (state_q == ST_RD_REQ);
    mem_write    = mem_write_q;
    mem_addr     = rd_active ? gen_addr : wr_addr_q;
    mem_data_out = wr_data_q;
    fb_ready     = (state_q == ST_WR) && !last_q && (!mem_write_q || mem_ready);
    fb_done      = (state_q == ST_DONE);
    busy         = (state_q != ST_IDLE);
    blk_line     = blk_line_q;
    blk_line_rdy = blk_line_rdy_q;
    blk_done     = blk_done_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: wide data registers are reset too, so every output reads 0
      // out of reset rather than carrying stale contents.
      stride_q       <= '0;
      width_q        <= '0;
      height_q       <= '0;
      bx_q           <= '0;
      by_q           <= '0;
      row_q          <= '0;
      x_pos_q        <= '0;
      y_pos_q        <= '0;
      last_q         <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      mem_write_q    <= 1'b0;
      blk_line_q     <= '0;
      blk_line_rdy_q <= 1'b0;
      blk_done_q     <= 1'b0;
    end else begin
      blk_line_rdy_q <= 1'b0;
      blk_done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (setup_frame) begin
            stride_q <= stride_in;
            width_q  <= width_in;
            height_q <= height_in;
          end else if (fb_write) begin
            x_pos_q <= '0;
            y_pos_q <= '0;
            last_q  <= 1'b0;
          end else if (read_block) begin
            bx_q  <= x;
            by_q  <= y;
            row_q <= '0;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            blk_line_q     <= mem_data;
            blk_line_rdy_q <= 1'b1;
            blk_done_q     <= last_row;
            if (!last_row) row_q <= row_q + ROW_W'(1);
          end
        end
        ST_WR: begin
          if (wr_accept) mem_write_q <= 1'b0;
          // A new beat may replace the one being accepted in the same cycle.
          if (fb_fire) begin
            wr_addr_q   <= gen_addr;
            wr_data_q   <= fb_data;
            mem_write_q <= 1'b1;
            last_q      <= last_beat;
            if (line_wrap) begin
              x_pos_q <= '0;
              y_pos_q <= y_pos_q + GEOM_W'(1);
            end else begin
              x_pos_q <= x_next[GEOM_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_block_engine.sv
// Directed testbench for fb_block_engine with a behavioural frame memory.
module tb_fb_block_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] stride_in, width_in, height_in;
  logic        setup_frame;
  logic [10:0] x, y;
  logic        read_block;
  logic [63:0] blk_line;
  logic        blk_line_rdy, blk_done;
  logic        fb_write;
  logic [63:0] fb_data;
  logic        fb_valid, fb_ready, fb_done, busy;
  logic [20:0] mem_addr;
  logic [63:0] mem_data_out;
  logic        mem_read, mem_write;
  logic        mem_ready;
  logic [63:0] mem_data;
  logic        mem_rvalid;

  always #5 clk = ~clk;

  fb_block_engine u_dut (
    .clk          (clk),
    .reset        (reset),
    .stride_in    (stride_in),
    .width_in     (width_in),
    .height_in    (height_in),
    .setup_frame  (setup_frame),
    .x            (x),
    .y            (y),
    .read_block   (read_block),
    .blk_line     (blk_line),
    .blk_line_rdy (blk_line_rdy),
    .blk_done     (blk_done),
    .fb_write     (fb_write),
    .fb_data      (fb_data),
    .fb_valid     (fb_valid),
    .fb_ready     (fb_ready),
    .fb_done      (fb_done),
    .busy         (busy),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_ready    (mem_ready),
    .mem_data     (mem_data),
    .mem_rvalid   (mem_rvalid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read data returned for an address: recognisable and address-unique.
  function automatic logic [63:0] pat(input logic [20:0] a);
    return {32'hC0DE0000 ^ {11'd0, a}, 11'd0, a};
  endfunction

  // ---------------- memory model and monitors ----------------
  int          rd_delay     = 1;
  bit          ready_toggle = 1'b0;
  logic [20:0] rd_log[$];
  logic [20:0] wr_addr_log[$];
  logic [63:0] wr_data_log[$];
  int          wr_cyc_log[$];
  logic [63:0] blk_log[$];
  bit          done_log[$];
  int          fb_done_cnt = 0;
  int          fb_done_cyc = 0;
  int          cyc = 0;

  initial begin
    int          cnt = 0;
    logic [20:0] raddr = '0;
    bit          prev_stall = 1'b0;
    logic [20:0] p_addr = '0;
    logic [63:0] p_data = '0;
    logic        p_rd = 1'b0, p_wr = 1'b0;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_data   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (prev_stall) begin
          check("stall_rd", mem_read, p_rd);
          check("stall_wr", mem_write, p_wr);
          check("stall_addr", mem_addr, p_addr);
          if (p_wr) check("stall_data", mem_data_out, p_data);
        end
        if (mem_read || mem_write) check("strobe_excl", mem_read && mem_write, 0);
        if (mem_write && !mem_ready) check("stall_fb_ready", fb_ready, 0);
        prev_stall = (mem_read || mem_write) && !mem_ready;
      end else begin
        prev_stall = 1'b0;
      end
      p_addr = mem_addr; p_data = mem_data_out; p_rd = mem_read; p_wr = mem_write;
      if (mem_read && mem_ready) begin
        rd_log.push_back(mem_addr);
        raddr = mem_addr;
        cnt   = rd_delay;
      end
      if (mem_write && mem_ready) begin
        wr_addr_log.push_back(mem_addr);
        wr_data_log.push_back(mem_data_out);
        wr_cyc_log.push_back(cyc);
      end
      if (blk_line_rdy) begin
        blk_log.push_back(blk_line);
        done_log.push_back(blk_done);
      end
      if (fb_done) begin
        fb_done_cnt++;
        fb_done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_data   = pat(raddr);
        end
      end
      mem_ready = ready_toggle ? ~mem_ready : 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    wr_cyc_log.delete(); blk_log.delete(); done_log.delete();
    fb_done_cnt = 0;
  endtask

  task automatic setup(input int w, input int h, input int s);
    width_in = 12'(w); height_in = 12'(h); stride_in = 12'(s);
    setup_frame = 1'b1;
    tick();
    setup_frame = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int c = 0;
    while (busy && c < limit) begin
      tick();
      c++;
    end
    check(tag, busy, 0);
    tick();
    tick();
  endtask

  task automatic do_write(input string tag, input int nbeats, input logic [63:0] base,
                          input bit with_read);
    int k = 0;
    int c = 0;
    bit acc;
    fb_write = 1'b1; fb_valid = 1'b1; fb_data = base;
    read_block = with_read;
    tick();
    fb_write = 1'b0;
    while (k < nbeats && c < 400) begin
      @(negedge clk);
      acc = fb_ready;
      @(posedge clk);
      #1;
      c++;
      if (acc) begin
        k++;
        fb_data = base + 64'(k);
      end
    end
    fb_valid = 1'b0;
    read_block = 1'b0;
    check({tag, "_beats"}, k, nbeats);
    wait_idle({tag, "_idle"}, 100);
  endtask

  task automatic do_read(input string tag, input int bx, input int by);
    x = 11'(bx); y = 11'(by);
    read_block = 1'b1;
    tick();
    read_block = 1'b0;
    wait_idle({tag, "_idle"}, 300);
  endtask

  // Compare logged reads and returned lines against expected row addresses.
  task automatic check_block(input string tag, input logic [20:0] ea [8]);
    check({tag, "_nrd"}, rd_log.size(), 8);
    check({tag, "_nline"}, blk_log.size(), 8);
    for (int r = 0; r < 8; r++) begin
      if (r < rd_log.size())  check($sformatf("%s_addr%0d", tag, r), rd_log[r], ea[r]);
      if (r < blk_log.size()) begin
        check($sformatf("%s_line%0d", tag, r), blk_log[r], pat(ea[r]));
        check($sformatf("%s_done%0d", tag, r), done_log[r], (r == 7));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [20:0] ea [8];
    reset = 1'b0; setup_frame = 1'b0; read_block = 1'b0; fb_write = 1'b0;
    fb_valid = 1'b0; fb_data = '0; x = '0; y = '0;
    stride_in = '0; width_in = '0; height_in = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data_out", mem_data_out, 0);
    check("rst_blk_line", blk_line, 0);
    check("rst_blk_line_rdy", blk_line_rdy, 0);
    check("rst_blk_done", blk_done, 0);
    check("rst_fb_done", fb_done, 0);
    check("rst_fb_ready", fb_ready, 0);
    reset = 1'b1;
    tick();

    // A: 64x4 frame, 32 back-to-back writes at 0,8,...,248.
    clear_logs();
    setup(64, 4, 64);
    do_write("A", 32, 64'hA000, 1'b0);
    check("A_nwr", wr_addr_log.size(), 32);
    for (int k = 0; k < 32; k++) begin
      if (k < wr_addr_log.size()) begin
        check($sformatf("A_addr%0d", k), wr_addr_log[k], 21'(k * 8));
        check($sformatf("A_data%0d", k), wr_data_log[k], 64'hA000 + 64'(k));
      end
    end
    check("A_fb_done_cnt", fb_done_cnt, 1);
    if (wr_cyc_log.size() == 32) begin
      check("A_throughput", wr_cyc_log[31] - wr_cyc_log[0], 31);
      check("A_done_timing", fb_done_cyc, wr_cyc_log[31] + 1);
    end

    // B: block at (8,0) in a 4-line frame, lower rows replicate line 3.
    clear_logs();
    do_read("B", 8, 0);
    ea = '{21'd8, 21'd72, 21'd136, 21'd200, 21'd200, 21'd200, 21'd200, 21'd200};
    check_block("B", ea);
    check("B_line_hold", blk_line, pat(21'd200));
    check("B_no_write", wr_addr_log.size(), 0);

    // C: width 60 clamps x=56 to 52; slow return and stalling memory.
    clear_logs();
    setup(60, 4, 64);
    rd_delay = 5;
    ready_toggle = 1'b1;
    do_read("C", 56, 0);
    ea = '{21'd52, 21'd116, 21'd180, 21'd244, 21'd244, 21'd244, 21'd244, 21'd244};
    check_block("C", ea);

    // D: write with mem_ready toggling, 60x2 frame, stride 100.
    clear_logs();
    rd_delay = 1;
    setup(60, 2, 100);
    do_write("D", 16, 64'hD000, 1'b0);
    check("D_nwr", wr_addr_log.size(), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < wr_addr_log.size()) begin
        check($sformatf("D_addr%0d", k), wr_addr_log[k], 21'((k / 8) * 100 + (k % 8) * 8));
        check($sformatf("D_data%0d", k), wr_data_log[k], 64'hD000 + 64'(k));
      end
    end
    check("D_fb_done_cnt", fb_done_cnt, 1);

    // E: read_block together with fb_write, and held while busy: write wins.
    clear_logs();
    ready_toggle = 1'b0;
    setup(16, 1, 16);
    do_write("E", 2, 64'hE000, 1'b1);
    check("E_nwr", wr_addr_log.size(), 2);
    if (wr_addr_log.size() == 2) begin
      check("E_addr0", wr_addr_log[0], 0);
      check("E_addr1", wr_addr_log[1], 8);
    end
    check("E_no_read", rd_log.size(), 0);
    check("E_fb_done_cnt", fb_done_cnt, 1);

    // F: reset while waiting for read data, then a late rvalid.
    clear_logs();
    rd_delay = 5;
    setup(64, 4, 64);
    x = '0; y = '0;
    read_block = 1'b1;
    tick();
    read_block = 1'b0;
    begin
      int c = 0;
      while (rd_log.size() == 0 && c < 20) begin
        tick();
        c++;
      end
    end
    check("F_req_seen", rd_log.size(), 1);
    check("F_in_wait", busy && !mem_read, 1);
    tick();
    reset = 1'b0;
    tick();
    check("F_rst_busy", busy, 0);
    check("F_rst_mem_read", mem_read, 0);
    check("F_rst_blk_line", blk_line, 0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("F_late_no_line", blk_log.size(), 0);
    check("F_late_rdy", blk_line_rdy, 0);
    check("F_late_busy", busy, 0);
    check("F_late_mem_read", mem_read, 0);
    check("F_late_blk_line", blk_line, 0);
    // Geometry was cleared by reset: width 0 finishes without any write.
    rd_delay = 1;
    do_write("F0", 0, 64'hF000, 1'b0);
    check("F0_no_write", wr_addr_log.size(), 0);
    check("F0_fb_done_cnt", fb_done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_block_engine.md
# fb_block_engine

Parametrised frame-buffer engine between the pixel pipeline and the frame memory. Two jobs: it streams a whole frame into memory in raster order using a valid/ready handshake, and it fetches a BLK_WIDTH×BLK_HEIGHT block at (x,y) one line per memory word. Block lines that fall outside the frame are clamped to the edge (edge replication). Memory accesses use a request/ready/return-valid protocol with one outstanding read, so any memory latency is tolerated.

## Interface
- MEM_WIDTH, 64, memory word width in bits; must equal BLK_WIDTH*8
- BLK_WIDTH, 8, block width in pixels (8-bit pixels)
- BLK_HEIGHT, 8, block height in lines
- ADDR_WIDTH, 21, memory address width (pixel/byte address)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- stride_in, width_in, height_in  in  12 each  frame geometry in pixels
- setup_frame  in  1  latch geometry (IDLE only)
- x, y  in  11 each  block position; x a multiple of BLK_WIDTH
- read_block  in  1  start block fetch (IDLE only)
- blk_line  out  MEM_WIDTH  one block line
- blk_line_rdy  out  1  blk_line valid, one-cycle pulse per line
- blk_done  out  1  pulse with last blk_line_rdy
- fb_write  in  1  start frame write (IDLE only)
- fb_data  in  MEM_WIDTH  line segment to write
- fb_valid  in  1  fb_data valid
- fb_ready  out  1  engine accepts fb_data
- fb_done  out  1  one-cycle pulse, frame write complete
- busy  out  1  state != IDLE
- mem_addr  out  ADDR_WIDTH  request address
- mem_data_out  out  MEM_WIDTH  write data
- mem_read, mem_write  out  1  request strobes, held until accepted
- mem_ready  in  1  memory accepts request this cycle
- mem_data  in  MEM_WIDTH  read return data
- mem_rvalid  in  1  mem_data valid

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- IDLE priority when commands coincide: setup_frame > fb_write > read_block. Commands outside IDLE are ignored.
- Address is y_eff*stride + x_eff, truncated to ADDR_WIDTH. The product is computed at 23 bits before truncation.
- Read: row counter r runs 0..BLK_HEIGHT-1.
  - y_eff = min(y+r, height-1).
  - x_eff = min(x, width-BLK_WIDTH); if width<BLK_WIDTH, x_eff=0.
  - RD_REQ drives mem_read until mem_ready, then moves to RD_WAIT.
  - On mem_rvalid, capture data into blk_line and pulse blk_line_rdy next cycle.
  - Then either return to RD_REQ with r+1, or, after the last row, pulse blk_done and go to IDLE.
- Write: x_pos, y_pos start at 0.
  - fb_ready = (state==WR) && (!mem_write || mem_ready).
  - On fb_valid&&fb_ready, register addr and data and assert mem_write; mem_write is held until mem_ready.
  - x_pos += BLK_WIDTH; when x_pos+BLK_WIDTH >= width, set x_pos=0 and y_pos+1.
  - After the write for the last line (y_pos==height-1) is accepted, go to DONE, pulse fb_done, return to IDLE.
  - width==0 or height==0: go to DONE with no writes.
- mem_rvalid outside RD_WAIT is ignored. mem_read and mem_write are never asserted together.
- Reset values: every output 0; stride, width and height registers 0; state IDLE.
- Reset mid-operation aborts immediately. No further memory strobes are issued, and a late mem_rvalid is ignored.

## Timing
- setup_frame at edge n: geometry usable by a command at edge n+1.
- read_block at edge n → mem_read high in cycle n+1.
- With mem_ready=1 and rvalid one cycle after accept, blk_line_rdy rises at n+3. Each following line takes 3 cycles.
- blk_line holds its value until the next capture.
- Write throughput is one line per cycle with mem_ready=1 and fb_valid=1.
- fb_done appears 1 cycle after the final write is accepted.
- Memory stall (mem_ready=0): mem_addr, mem_data_out and the strobe stay stable; fb_ready is 0.

## Structure
- Package fb_pkg holds:
  - state encoding
  - geometry width (12)
  - default parameter values
  - a function for the MEM_WIDTH==BLK_WIDTH*8 check
- Sub-module fb_addr_gen (combinational clamp plus multiply-add) is shared by the read and write paths.

## Test plan
- Geometry 64×4, stride 64; fb_write with 32 back-to-back lines, mem_ready=1:
  - 32 writes at addresses 0,8,…,56,64,…,248
  - fb_done exactly once, after the last write.
- Block read at x=8,y=0, BLK_HEIGHT=8, height=4:
  - row addresses 8,72,136,200,200,200,200,200
  - 8 blk_line_rdy pulses; blk_done on the 8th.
- Block read at x=56 with width=60: x clamped to 52, first address 52.
- mem_ready toggling 0/1 during a write and rvalid delayed 5 cycles during a read:
  - strobes and address stable while stalled
  - no lost or duplicated lines.
- read_block and fb_write asserted together in IDLE: write executes and read_block is dropped. read_block while busy is ignored.
- reset low during RD_WAIT followed by a stray mem_rvalid:
  - all outputs 0, state IDLE, no blk_line_rdy
  - width=0 fb_write then gives fb_done with no mem_write.
